// File: rtl/airlock_pkg.sv
// Shared types for the airlock chamber sequencer.
// State encoding and direction codes.
package airlock_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INNER_OPEN,
        EVAC_START,
        EVAC_RISE,
        EVAC_FALL,
        OUTER_OPEN,
        PRESS_START,
        PRESS_RISE,
        PRESS_FALL,
        FAULT
    } airlock_state_t;

    localparam logic DIR_ARRIVE = 1'b0;
    localparam logic DIR_DEPART = 1'b1;

endpackage

// File: rtl/airlock_sequencer_dwell_timer.sv
// Loadable down-counter that stops at 1; expired flags the last cycle.
// Shared by the door dwell and the pump watchdog.
module dwell_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count > W'(1)) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == W'(1));

endmodule

// File: rtl/airlock_sequencer.sv
// Door/pump sequencing FSM for the interlock chamber.
// Optional pump watchdog and FAULT state: define AIRLOCK_WATCHDOG_EN.
module airlock_sequencer
    import airlock_pkg::*;
#(
    parameter int DOOR_CYCLES     = 30,
    parameter int WATCHDOG_CYCLES = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic arrive_req,
    input  logic depart_req,
    input  logic press_busy,
    input  logic evac_busy,
    output logic press_start,
    output logic evac_start,
    output logic outer_door_open,
    output logic inner_door_open,
    output logic chamber_pressurized,
    output logic seq_active,
    output logic fault
);

    localparam int DW = $clog2(DOOR_CYCLES + 1);

    airlock_state_t state;
    airlock_state_t state_n;
    logic           dir;

    logic door_n;
    logic dwell_load;
    logic dwell_en;
    logic dwell_done;
    logic wd_done;

    assign door_n     = (state_n == INNER_OPEN) ||
                        (state_n == OUTER_OPEN);
    assign dwell_load = door_n && (state_n != state);
    assign dwell_en   = (state == INNER_OPEN) ||
                        (state == OUTER_OPEN);

    dwell_timer #(
        .W (DW)
    ) u_dwell (
        .clock    (clock),
        .reset    (reset),
        .load     (dwell_load),
        .load_val (DW'(DOOR_CYCLES)),
        .en       (dwell_en),
        .expired  (dwell_done)
    );

`ifdef AIRLOCK_WATCHDOG_EN
    localparam int WW = $clog2(WATCHDOG_CYCLES + 1);

    logic wd_load;
    logic wd_en;

    // Armed with the start pulse so the limit counts from the pulse itself.
    assign wd_load = (state_n != state) &&
                     ((state_n == EVAC_START) ||
                      (state_n == PRESS_START));
    assign wd_en   = (state == EVAC_START) ||
                     (state == EVAC_RISE) ||
                     (state == PRESS_START) ||
                     (state == PRESS_RISE);

    dwell_timer #(
        .W (WW)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .load     (wd_load),
        .load_val (WW'(WATCHDOG_CYCLES)),
        .en       (wd_en),
        .expired  (wd_done)
    );
`else
    assign wd_done = 1'b0;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (arrive_req) begin
                    state_n = EVAC_START;
                end else if (depart_req) begin
                    state_n = INNER_OPEN;
                end
            end
            INNER_OPEN: begin
                if (dwell_done) begin
                    state_n = (dir == DIR_DEPART) ? EVAC_START : IDLE;
                end
            end
            EVAC_START: state_n = EVAC_RISE;
            EVAC_RISE: begin
                if (evac_busy) begin
                    state_n = EVAC_FALL;
                end else if (wd_done) begin
                    state_n = FAULT;
                end
            end
            EVAC_FALL: begin
                if (!evac_busy) begin
                    state_n = OUTER_OPEN;
                end
            end
            OUTER_OPEN: begin
                if (dwell_done) begin
                    state_n = PRESS_START;
                end
            end
            PRESS_START: state_n = PRESS_RISE;
            PRESS_RISE: begin
                if (press_busy) begin
                    state_n = PRESS_FALL;
                end else if (wd_done) begin
                    state_n = FAULT;
                end
            end
            PRESS_FALL: begin
                if (!press_busy) begin
                    state_n = (dir == DIR_DEPART) ? IDLE : INNER_OPEN;
                end
            end
`ifdef AIRLOCK_WATCHDOG_EN
            FAULT:   state_n = FAULT;
`else
            FAULT:   state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            dir                 <= DIR_ARRIVE;
            press_start         <= 1'b0;
            evac_start          <= 1'b0;
            outer_door_open     <= 1'b0;
            inner_door_open     <= 1'b0;
            chamber_pressurized <= 1'b1;
            seq_active          <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n != IDLE) begin
                dir <= arrive_req ? DIR_ARRIVE : DIR_DEPART;
            end
            press_start     <= (state_n == PRESS_START);
            evac_start      <= (state_n == EVAC_START);
            outer_door_open <= (state_n == OUTER_OPEN);
            inner_door_open <= (state_n == INNER_OPEN);
            seq_active      <= (state_n != IDLE);
            if (state == EVAC_FALL && state_n != EVAC_FALL) begin
                chamber_pressurized <= 1'b0;
            end else if (state == PRESS_FALL && state_n != PRESS_FALL) begin
                chamber_pressurized <= 1'b1;
            end
        end
    end

`ifdef AIRLOCK_WATCHDOG_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault <= 1'b0;
        end else begin
            fault <= (state_n == FAULT);
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: doc/airlock_sequencer.md
# airlock_sequencer

Top-level control FSM for the interlock chamber. It sequences the two chamber doors and issues one-cycle start pulses to the pressurizer and the evacuator, which sit directly downstream. It tracks each pump's busy/done handshake through to completion. The chamber rests pressurized with both doors closed; an arrival or a departure request runs one complete, non-interruptible door/pump sequence.

## Interface
Parameters:
- `DOOR_CYCLES`, default 30: clock cycles a door stays open per door phase. Must be at least 1.
- `WATCHDOG_CYCLES`, default 8: maximum cycles from a start pulse until that pump's busy must rise. Used only with the watchdog macro.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `arrive_req`  in  1  craft outside requests entry; level, sampled only in IDLE.
- `depart_req`  in  1  craft inside requests exit; level, sampled only in IDLE.
- `press_busy`  in  1  pressurizer's pressurizing output.
- `evac_busy`  in  1  evacuator's busy output.
- `press_start`  out  1  one-cycle pulse to the pressurizer's start input.
- `evac_start`  out  1  one-cycle pulse to the evacuator's start input.
- `outer_door_open`  out  1  outer door actuator; high means open.
- `inner_door_open`  out  1  inner door actuator; high means open.
- `chamber_pressurized`  out  1  chamber at inside pressure.
- `seq_active`  out  1  high whenever the FSM is not in IDLE.
- `fault`  out  1  watchdog fault. Only exists with the watchdog macro; otherwise tied 0.

## Operation
- States: IDLE, INNER_OPEN, EVAC_START, EVAC_RISE, EVAC_FALL, OUTER_OPEN, PRESS_START, PRESS_RISE, PRESS_FALL, FAULT.
- A 1-bit `dir` register is latched when leaving IDLE: 0 = arrive, 1 = depart.
- Arrive sequence: IDLE → EVAC_START → EVAC_RISE → EVAC_FALL → OUTER_OPEN → PRESS_START → PRESS_RISE → PRESS_FALL → INNER_OPEN → IDLE.
- Depart sequence: IDLE → INNER_OPEN → EVAC_START → EVAC_RISE → EVAC_FALL → OUTER_OPEN → PRESS_START → PRESS_RISE → PRESS_FALL → IDLE.
- The transition out of INNER_OPEN depends on `dir`: arrive goes to IDLE, depart goes to EVAC_START.
- X_START states: the matching start output is high for exactly that one cycle; the FSM then moves to X_RISE.
- X_RISE: wait for busy = 1, then go to X_FALL.
  - This two-step wait is required because the pump registers start internally, so busy is still low for 2 cycles after the pulse.
- X_FALL: wait for busy = 0.
  - On leaving EVAC_FALL, clear `chamber_pressurized`.
  - On leaving PRESS_FALL, set `chamber_pressurized`.
- Door states: the matching door output is high for exactly `DOOR_CYCLES` cycles, then goes low on the state exit.
  - The two doors are never open at the same time.
  - A door is never open while either start or busy is high.
- Arbitration in IDLE: if both requests are high in the same cycle, arrive wins. Requests that arrive outside IDLE are dropped, not queued.
- Busy inputs are ignored outside their own RISE/FALL states.
- Dwell counter is `$clog2(DOOR_CYCLES+1)` bits. It loads on door-state entry, counts down, and the FSM exits when it reaches 1. It never wraps.
- All outputs are registered, driven from the next-state decode.

## Timing
- Reset values:
  - FSM state = IDLE, `dir` = 0, dwell counter = 0.
  - All outputs 0 except `chamber_pressurized` = 1.
- Request to first action: a request seen at edge n puts the FSM in a new state at edge n+1. The start pulse or door open is visible from n+1.
- Start pulse to busy high: 2 cycles with the current pressurizer. The FSM accepts any delay of 1 or more cycles.
- Busy falling at edge m: the FSM leaves X_FALL at edge m+1, and the next start pulse or door open is visible from m+1.
- Reset asserted mid-sequence: all outputs return to their reset values immediately, without waiting for a clock edge.
  - `chamber_pressurized` = 1 after reset is a decided system-level assumption; the pumps are reset by the same signal.

## Configuration
- `AIRLOCK_WATCHDOG_EN` defined:
  - In EVAC_RISE or PRESS_RISE, a counter counts cycles since the start pulse.
  - If busy has not risen after `WATCHDOG_CYCLES` cycles, go to FAULT.
  - FAULT closes both doors, drives `fault` = 1 and `seq_active` = 1, and holds until `reset`.
- `AIRLOCK_WATCHDOG_EN` undefined:
  - No watchdog counter and no FAULT state; RISE states wait indefinitely.
  - `fault` is tied 0.

## Structure
- Package `airlock_pkg` holds:
  - the state enum `airlock_state_t`;
  - `DIR_ARRIVE` = 0 and `DIR_DEPART` = 1.
- One sub-module, `dwell_timer`: load/count-down/expire, parameterised width, reused for the door dwell and the watchdog.
- The pressurizer and evacuator are instantiated by the parent, not inside this block.

## Test plan
- Reset → all outputs 0, `chamber_pressurized` = 1, `seq_active` = 0. Reset asserted with `DOOR_CYCLES`=4 while in OUTER_OPEN → `outer_door_open` = 0 immediately, state IDLE.
- Arrive, `DOOR_CYCLES`=4, busy stubs pulled high 2 cycles after start and held 10 cycles, expect in order:
  - one `evac_start` pulse;
  - `chamber_pressurized` = 0;
  - outer door open 4 cycles;
  - one `press_start` pulse;
  - `chamber_pressurized` = 1;
  - inner door open 4 cycles;
  - IDLE.
- Depart with the same stubs → inner door 4 cycles, evac, outer door 4 cycles, press, IDLE. Doors never overlap.
- `arrive_req` and `depart_req` high in the same cycle → arrive sequence runs. `depart_req` pulsed during PRESS_FALL → ignored, and FSM returns to IDLE.
- Busy delayed 5 cycles after start → FSM stays in RISE, no early advance. With busy delayed 2 cycles, FSM is not fooled by the initial busy = 0.
- `AIRLOCK_WATCHDOG_EN`, `WATCHDOG_CYCLES`=8, `evac_busy` stuck 0 → FAULT and `fault` = 1 after 8 cycles, doors closed, FAULT held until reset.
